// File: rtl/sh_frt_multi_pkg.sv
// Shared types, register offsets and field masks for the multi-channel free-running timer.
package sh_frt_multi_pkg;

    localparam logic [5:0] OFS_CTRL = 6'h00;
    localparam logic [5:0] OFS_STAT = 6'h04;
    localparam logic [5:0] OFS_IER  = 6'h08;
    localparam logic [5:0] OFS_CNT  = 6'h0C;
    localparam logic [5:0] OFS_OCR  = 6'h10;
    localparam logic [5:0] OFS_ICR  = 6'h30;

    typedef enum logic [1:0] {
        CKS_DIV8   = 2'd0,
        CKS_DIV32  = 2'd1,
        CKS_DIV128 = 2'd2,
        CKS_EXT    = 2'd3
    } cksSel_e;

    typedef struct packed {
        logic        cclr;
        logic [10:0] rsv3;
        logic [3:0]  tolvl;
        logic [3:0]  rsv2;
        logic [3:0]  iedg;
        logic [5:0]  rsv1;
        cksSel_e     cks;
    } frtmCtrl_t;

    typedef struct packed {
        logic [6:0] rsv4;
        logic       ovf;
        logic [3:0] rsv3;
        logic [3:0] ovr;
        logic [3:0] rsv2;
        logic [3:0] icf;
        logic [3:0] rsv1;
        logic [3:0] ocf;
    } frtmStat_t;

    localparam logic [31:0] CTRL_INIT = 32'h0000_0000;
    localparam logic [31:0] STAT_INIT = 32'h0000_0000;

    function automatic logic [3:0] lowOnes(input int n);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (k < n) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ctrlMask(input int noc, input int nic);
        frtmCtrl_t m;
        m       = '0;
        m.cclr  = 1'b1;
        m.tolvl = lowOnes(noc);
        m.iedg  = lowOnes(nic);
        m.cks   = CKS_EXT;
        return m;
    endfunction

    // IER shares the STAT layout but has no overrun enables
    function automatic logic [31:0] statMask(input int noc, input int nic, input logic withOvr);
        frtmStat_t m;
        m     = '0;
        m.ovf = 1'b1;
        m.ocf = lowOnes(noc);
        m.icf = lowOnes(nic);
        m.ovr = withOvr ? lowOnes(nic) : 4'h0;
        return m;
    endfunction

    function automatic logic [31:0] byteMerge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

endpackage

// File: rtl/sh_frt_multi_if.sv
// Internal peripheral bus (IBUS) bundle between the CPU side and the timer register block.
interface sh_frt_multi_if;
    logic [31:0] addr;
    logic [31:0] wrData;
    logic [3:0]  byteEn;
    logic        wrEn;
    logic        req;
    logic [31:0] rdData;
    logic        busy;
    logic        act;

    modport master (output addr, wrData, byteEn, wrEn, req, input rdData, busy, act);
    modport slave  (input addr, wrData, byteEn, wrEn, req, output rdData, busy, act);
endinterface

// File: rtl/sh_frt_multi_capbuf.sv
// Two-entry capture FIFO; a push into a full buffer is dropped and flagged unless a pop frees a slot.
module sh_frt_multi_capbuf #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         ovr_o
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] last_q;
    logic         wrPtr_q;
    logic         rdPtr_q;
    logic [1:0]   count_q;
    logic         doPush;
    logic         doPop;

    assign doPop   = pop_i & (count_q != 2'd0);
    assign doPush  = push_i & ((count_q != 2'd2) | doPop);
    assign ovr_o   = push_i & ~doPush;
    assign empty_o = (count_q == 2'd0);
    // An empty buffer keeps presenting the most recently popped value
    assign data_o  = empty_o ? last_q : mem_q[rdPtr_q];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_q   <= '{default: '0};
            last_q  <= '0;
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else if (clr_i) begin
            mem_q   <= '{default: '0};
            last_q  <= '0;
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (doPop) begin
                last_q  <= mem_q[rdPtr_q];
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + 2'(doPush) - 2'(doPop);
        end
    end

endmodule

// File: rtl/sh_frt_multi.sv
// Free-running timer: up-counter, output-compare and buffered input-capture channels on the IBUS.
module sh_frt_multi
    import sh_frt_multi_pkg::*;
#(
    parameter int          CNT_W = 16,
    parameter int          NOC   = 2,
    parameter int          NIC   = 1,
    parameter logic [31:0] BASE  = 32'hFFFF_FE40
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           CE_R_i,
    input  logic           CE_F_i,
    input  logic           EN_i,
    input  logic           RES_N_i,
    input  logic           SBY_i,
    input  logic           CLK8_CE_i,
    input  logic           CLK32_CE_i,
    input  logic           CLK128_CE_i,
    input  logic           FTCI_i,
    input  logic [NIC-1:0] FTI_i,
    output logic [NOC-1:0] FTO_o,
    output logic [NOC-1:0] OCI_IRQ_o,
    output logic [NIC-1:0] ICI_IRQ_o,
    output logic           OVI_IRQ_o,
    sh_frt_multi_if.slave  ibus
);

    localparam logic [31:0]      CTRL_WMASK = ctrlMask(NOC, NIC);
    localparam logic [31:0]      IER_WMASK  = statMask(NOC, NIC, 1'b0);
    localparam logic [CNT_W-1:0] CNT_ONES   = '1;

    frtmCtrl_t        ctrl_q, ctrl_d;
    logic [31:0]      ier_q, ier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ocr_q [NOC];
    logic [CNT_W-1:0] ocr_d [NOC];
    logic [NOC-1:0]   ocf_q, ocf_d;
    logic [NOC-1:0]   fto_q, fto_d;
    logic [NIC-1:0]   ovr_q, ovr_d;
    logic             ovf_q, ovf_d;
    logic [NIC-1:0]   ftiSync_q, ftiPrev_q;
    logic             ftci_q;
    logic [NIC-1:0]   popPend_q;
    logic             reqDone_q;
    logic [31:0]      rdData_q;

    logic             tick, softRst, ceCnt, cntTick, ovfSet;
    logic             hit, rdReq, wrReq;
    logic [5:0]       ofs;
    logic [NOC-1:0]   match;
    logic [NIC-1:0]   capEdge, capPop, capEmpty, capOvr, icrSel;
    logic [CNT_W-1:0] capData [NIC];
    logic [31:0]      rdWord;
    frtmStat_t        statWord, statClr;

    function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[CNT_W-1:0] = v;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] mergeCnt(input logic [CNT_W-1:0] old,
                                                  input logic [CNT_W-1:0] wd,
                                                  input logic [3:0] be);
        logic [CNT_W-1:0] r;
        r = old;
        for (int b = 0; b < CNT_W; b++) if (be[b/8]) r[b] = wd[b];
        return r;
    endfunction

    assign tick    = CE_R_i & EN_i;
    assign softRst = CE_R_i & (~RES_N_i | SBY_i);
    assign ofs     = ibus.addr[5:0];
    assign hit     = ibus.req & (ibus.addr[31:6] == BASE[31:6]);
    assign rdReq   = hit & ~ibus.wrEn;
    assign wrReq   = hit & ibus.wrEn & tick;
    // Lanes written as 0 mark flags to clear; disabled lanes clear nothing
    assign statClr = ~byteMerge(32'hFFFF_FFFF, ibus.wrData, ibus.byteEn);

    always_comb begin
        ceCnt = 1'b0;
        case (ctrl_q.cks)
            CKS_DIV8:   ceCnt = CLK8_CE_i;
            CKS_DIV32:  ceCnt = CLK32_CE_i;
            CKS_DIV128: ceCnt = CLK128_CE_i;
            CKS_EXT:    ceCnt = FTCI_i & ~ftci_q;
            default:    ceCnt = 1'b0;
        endcase
    end

    assign cntTick = tick & ceCnt;
    assign ovfSet  = cntTick & ~(ctrl_q.cclr & match[0]) & (cnt_q == CNT_ONES);

    always_comb begin
        match = '0;
        for (int i = 0; i < NOC; i++) match[i] = cntTick & (cnt_q == ocr_q[i]);
    end

    for (genvar j = 0; j < NIC; j++) begin : g_cap
        assign capEdge[j] = tick & (ctrl_q.iedg[j] ? (ftiSync_q[j] & ~ftiPrev_q[j])
                                                   : (~ftiSync_q[j] & ftiPrev_q[j]));
        assign capPop[j]  = tick & popPend_q[j];

        sh_frt_multi_capbuf #(.W(CNT_W)) u_capbuf (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .clr_i   (softRst),
            .push_i  (capEdge[j]),
            .pop_i   (capPop[j]),
            .data_i  (cnt_q),
            .data_o  (capData[j]),
            .empty_o (capEmpty[j]),
            .ovr_o   (capOvr[j])
        );
    end

    always_comb begin
        statWord                = '0;
        statWord.ovf            = ovf_q;
        statWord.ocf[NOC-1:0]   = ocf_q;
        statWord.ovr[NIC-1:0]   = ovr_q;
        statWord.icf[NIC-1:0]   = ~capEmpty;
    end

    always_comb begin
        rdWord = '0;
        icrSel = '0;
        case (ofs)
            OFS_CTRL: rdWord = ctrl_q;
            OFS_STAT: rdWord = statWord;
            OFS_IER:  rdWord = ier_q;
            OFS_CNT:  rdWord = zext(cnt_q);
            default:  rdWord = '0;
        endcase
        for (int i = 0; i < NOC; i++)
            if (ofs == OFS_OCR + 6'(4 * i)) rdWord = zext(ocr_q[i]);
        for (int j = 0; j < NIC; j++)
            if (ofs == OFS_ICR + 6'(4 * j)) begin
                rdWord    = zext(capData[j]);
                icrSel[j] = 1'b1;
            end
    end

    // Counting first, then CPU writes/clears override, then flag-set events override clears
    always_comb begin
        ctrl_d = ctrl_q;
        ier_d  = ier_q;
        cnt_d  = cnt_q;
        ocr_d  = ocr_q;
        ocf_d  = ocf_q;
        ovr_d  = ovr_q;
        ovf_d  = ovf_q;
        fto_d  = fto_q;
        if (cntTick) begin
            if (ctrl_q.cclr & match[0]) cnt_d = '0;
            else                        cnt_d = cnt_q + 1'b1;
        end
        for (int i = 0; i < NOC; i++) if (match[i]) fto_d[i] = ctrl_q.tolvl[i];
        if (wrReq) begin
            case (ofs)
                OFS_CTRL: ctrl_d = byteMerge(ctrl_q, ibus.wrData, ibus.byteEn) & CTRL_WMASK;
                OFS_IER:  ier_d  = byteMerge(ier_q, ibus.wrData, ibus.byteEn) & IER_WMASK;
                OFS_CNT:  cnt_d  = mergeCnt(cnt_q, ibus.wrData[CNT_W-1:0], ibus.byteEn);
                OFS_STAT: begin
                    ocf_d = ocf_q & ~statClr.ocf[NOC-1:0];
                    ovr_d = ovr_q & ~statClr.ovr[NIC-1:0];
                    ovf_d = ovf_q & ~statClr.ovf;
                end
                default: begin
                    for (int i = 0; i < NOC; i++)
                        if (ofs == OFS_OCR + 6'(4 * i))
                            ocr_d[i] = mergeCnt(ocr_q[i], ibus.wrData[CNT_W-1:0], ibus.byteEn);
                end
            endcase
        end
        ocf_d = ocf_d | match;
        ovr_d = ovr_d | capOvr;
        if (ovfSet) ovf_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_q    <= CTRL_INIT;
            ier_q     <= STAT_INIT;
            cnt_q     <= '0;
            ocr_q     <= '{default: '1};
            ocf_q     <= '0;
            ovr_q     <= '0;
            ovf_q     <= 1'b0;
            fto_q     <= '0;
            ftiSync_q <= '0;
            ftiPrev_q <= '0;
            ftci_q    <= 1'b0;
        end else if (softRst) begin
            ctrl_q    <= CTRL_INIT;
            ier_q     <= STAT_INIT;
            cnt_q     <= '0;
            ocr_q     <= '{default: '1};
            ocf_q     <= '0;
            ovr_q     <= '0;
            ovf_q     <= 1'b0;
            fto_q     <= '0;
            ftiSync_q <= '0;
            ftiPrev_q <= '0;
            ftci_q    <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ier_q  <= ier_d;
            cnt_q  <= cnt_d;
            ocr_q  <= ocr_d;
            ocf_q  <= ocf_d;
            ovr_q  <= ovr_d;
            ovf_q  <= ovf_d;
            fto_q  <= fto_d;
            if (tick) begin
                ftiSync_q <= FTI_i;
                ftiPrev_q <= ftiSync_q;
                ftci_q    <= FTCI_i;
            end
        end
    end

    // A stalled read holding REQ high must pop the capture buffer only once
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            popPend_q <= '0;
            reqDone_q <= 1'b0;
            rdData_q  <= '0;
        end else if (softRst) begin
            popPend_q <= '0;
            reqDone_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            if (tick) popPend_q <= '0;
            if (CE_F_i & EN_i) begin
                rdData_q  <= rdReq ? rdWord : 32'h0;
                reqDone_q <= rdReq;
                if (rdReq & ~reqDone_q) popPend_q <= popPend_q | (icrSel & ~capEmpty);
            end
        end
    end

    assign FTO_o       = fto_q;
    assign OCI_IRQ_o   = ocf_q & ier_q[NOC-1:0];
    assign ICI_IRQ_o   = ~capEmpty & ier_q[NIC+7:8];
    assign OVI_IRQ_o   = ovf_q & ier_q[24];
    assign ibus.rdData = rdData_q;
    assign ibus.busy   = 1'b0;
    assign ibus.act    = hit;

endmodule
